// File: rtl/dsc_pkg.sv
// Shared types and constants for the DSC operation sequencer.
// Optional feature macro: DSC_EARLY_TERM_EN (cycle-budget early termination).
package dsc_pkg;

  // Sequencer phases around one core operation
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_HOLD
  } seq_state_e;

  // Fixed per-operation overhead around the RUN phase (CLEAR, DRAIN, HOLD,
  // IDLE): one operation with N RUN cycles occupies N + MIN_CYC_DSC cycles.
  localparam int MIN_CYC_DSC = 4;

  // Cycle counter wide enough for every core run length (WXIP1)
  function automatic int cnt_width(input int num_inputs, input int data_width);
    return num_inputs * data_width + 1;
  endfunction

endpackage

// File: rtl/counter.sv
// Up-counter with synchronous clear and enable; overflow pulses on carry-out.
module counter #(
  parameter int WIDTH  = 8,
  parameter int STRIDE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, count} + (WIDTH+1)'(STRIDE);

  // Count register: clear wins over enable, carry-out reported for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (en) begin
      count    <= sum[WIDTH-1:0];
      overflow <= sum[WIDTH];
    end else begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/dsc_op_sequencer.sv
// Control stage in front of the DSC core: takes one operand set, clears and
// runs the core, counts run cycles, then hands result + cycle count downstream.
// Optional feature macro: DSC_EARLY_TERM_EN adds a per-operation cycle budget.
module dsc_op_sequencer
  import dsc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 2,
  parameter int CNT_WIDTH  = cnt_width(NUM_INPUTS, DATA_WIDTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [CNT_WIDTH-1:0]             in_budget,
  output logic                             core_rst,
  output logic                             core_en,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] core_result,
  input  logic                             core_done,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] out_result,
  output logic [CNT_WIDTH-1:0]             out_cycles,
  output logic                             out_truncated
);

  seq_state_e           state_q, state_n;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 accept;
  logic                 budget_hit;
  logic                 sat_hit;
  logic                 run_exit;
  logic                 trunc_q;
  logic                 ovf;
  logic                 unused_ok;

  assign accept  = in_valid && in_ready;
  // Terminate conditions look at the count including the current RUN cycle
  assign cnt_inc = cnt + CNT_WIDTH'(1);
  assign sat_hit = &cnt_inc;

`ifdef DSC_EARLY_TERM_EN
  logic [CNT_WIDTH-1:0] budget_q;

  // Budget is latched together with the operands; zero means unlimited
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      budget_q <= '0;
    else if (accept) budget_q <= in_budget;
  end

  assign budget_hit = (budget_q != '0) && (cnt_inc == budget_q);
  assign unused_ok  = ovf;
`else
  assign budget_hit = 1'b0;
  assign unused_ok  = ^{ovf, in_budget};
`endif

  assign run_exit = (state_q == ST_RUN) && (core_done || budget_hit || sat_hit);

  // Run-cycle counter: held clear whenever the core is held clear
  counter #(
    .WIDTH (CNT_WIDTH),
    .STRIDE(1)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .rst     (core_rst),
    .en      (core_en),
    .count   (cnt),
    .overflow(ovf)
  );

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_n = ST_CLEAR;
      ST_CLEAR: state_n = ST_RUN;
      ST_RUN:   if (run_exit) state_n = ST_DRAIN;
      ST_DRAIN: state_n = ST_HOLD;
      ST_HOLD:  if (out_ready) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // State and handshake/core controls, registered from the next state so
  // every control output changes on the same edge as the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      in_ready  <= 1'b0;
      core_rst  <= 1'b1;
      core_en   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_n;
      in_ready  <= (state_n == ST_IDLE);
      core_rst  <= (state_n == ST_IDLE) || (state_n == ST_CLEAR);
      core_en   <= (state_n == ST_RUN);
      out_valid <= (state_n == ST_HOLD);
    end
  end

  // Operand hold register: only reloaded on an accepted operand set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      core_data <= '0;
    else if (accept) core_data <= in_data;
  end

  // Remember why RUN ended; core_done wins over a coincident budget hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        trunc_q <= 1'b0;
    else if (run_exit) trunc_q <= !core_done;
  end

  // Result capture in DRAIN, after the core has had a cycle to settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result    <= '0;
      out_cycles    <= '0;
      out_truncated <= 1'b0;
    end else if (state_q == ST_DRAIN) begin
      out_result    <= core_result;
      out_cycles    <= cnt;
      out_truncated <= trunc_q;
    end
  end

endmodule

// File: tb/tb_dsc_op_sequencer.sv
// Bench for dsc_op_sequencer: behavioural core model, vector table, random
// operations against a reference model, reset and saturation sequences.
module tb_dsc_op_sequencer;
  import dsc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (default widths)
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] in_data = '0;
  logic [16:0] in_budget = '0;
  logic        core_rst, core_en, core_done;
  logic [15:0] core_data, core_result;
  logic        out_valid, out_ready = 1'b1;
  logic [15:0] out_result;
  logic [16:0] out_cycles;
  logic        out_truncated;

  dsc_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_budget(in_budget), .core_rst(core_rst),
    .core_en(core_en), .core_data(core_data), .core_result(core_result),
    .core_done(core_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_cycles(out_cycles),
    .out_truncated(out_truncated)
  );

  // Narrow-counter DUT whose core never finishes
  logic        in_valid_b = 1'b0, in_ready_b;
  logic [15:0] in_data_b = 16'h0201;
  logic [3:0]  in_budget_b = '0;
  logic        core_rst_b, core_en_b;
  logic [15:0] core_data_b;
  logic        out_valid_b;
  logic [15:0] out_result_b;
  logic [3:0]  out_cycles_b;
  logic        out_truncated_b;

  dsc_op_sequencer #(.CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .in_budget(in_budget_b), .core_rst(core_rst_b),
    .core_en(core_en_b), .core_data(core_data_b), .core_result(16'h1234),
    .core_done(1'b0), .out_valid(out_valid_b), .out_ready(1'b1),
    .out_result(out_result_b), .out_cycles(out_cycles_b),
    .out_truncated(out_truncated_b)
  );

  // Core model: done during its D-th enabled cycle; the product once done,
  // otherwise the number of enabled cycles seen so far as a partial value
  int          d_cfg = 1;
  int          ccnt = 0;
  logic [15:0] prod;
  assign prod        = 16'(core_data[7:0]) * 16'(core_data[15:8]);
  assign core_done   = core_en && (ccnt + 1 >= d_cfg);
  assign core_result = (ccnt >= d_cfg) ? prod : 16'(ccnt);

  always @(posedge clk) begin
    if (core_rst)     ccnt <= 0;
    else if (core_en) ccnt <= ccnt + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [16:0] bud;
    int          d;
    int          hold;
    int          exp_n;
    logic        exp_tr;
    logic [15:0] exp_res;
  } vec_t;

  // One operation starting at a negedge in IDLE; ends at the negedge after
  // the output handshake
  task automatic do_op(input vec_t v);
    logic [15:0] opd;
    int t, lat;
    opd       = {v.b, v.a};
    d_cfg     = v.d;
    in_data   = opd;
    in_budget = v.bud;
    in_valid  = 1'b1;
    out_ready = (v.hold == 0);
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    chk("accept_immediate", t, 0);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    chk("clear_rst", core_rst, 1);
    chk("clear_en", core_en, 0);
    chk("clear_inrdy", in_ready, 0);
    chk("clear_data", core_data, opd);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        chk("run_en", core_en, 1);
        chk("run_rst", core_rst, 0);
      end
    end
    chk("latency", lat, v.exp_n + 3);
    chk("cycles", out_cycles, v.exp_n);
    chk("trunc", out_truncated, v.exp_tr);
    chk("result", out_result, v.exp_res);
    chk("hold_data", core_data, opd);
    chk("hold_en", core_en, 0);
    if (v.hold > 0) begin
      // queue the next request while the output is stalled
      in_valid = 1'b1;
      in_data  = 16'hA55A;
      repeat (v.hold) begin
        @(negedge clk);
        lat++;
        chk("stall_valid", out_valid, 1);
        chk("stall_res", out_result, v.exp_res);
        chk("stall_cyc", out_cycles, v.exp_n);
        chk("stall_inrdy", in_ready, 0);
        chk("stall_data", core_data, opd);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    lat++;
    chk("post_valid", out_valid, 0);
    chk("post_inrdy", in_ready, 1);
    chk("post_rst", core_rst, 1);
    if (v.hold == 0) chk("turnaround", lat, v.exp_n + MIN_CYC_DSC);
  endtask

  vec_t tbl[6];

  initial begin
    vec_t v;
    int lat;

    // Directed vectors
    tbl[0] = '{a: 3,   b: 5,   bud: 0,  d: 10, hold: 0, exp_n: 10, exp_tr: 0, exp_res: 15};
`ifdef DSC_EARLY_TERM_EN
    tbl[1] = '{a: 3,   b: 5,   bud: 4,  d: 10, hold: 0, exp_n: 4,  exp_tr: 1, exp_res: 4};
    tbl[4] = '{a: 200, b: 100, bud: 3,  d: 6,  hold: 5, exp_n: 3,  exp_tr: 1, exp_res: 3};
`else
    tbl[1] = '{a: 3,   b: 5,   bud: 4,  d: 10, hold: 0, exp_n: 10, exp_tr: 0, exp_res: 15};
    tbl[4] = '{a: 200, b: 100, bud: 3,  d: 6,  hold: 5, exp_n: 6,  exp_tr: 0, exp_res: 20000};
`endif
    tbl[2] = '{a: 3,   b: 5,   bud: 10, d: 10, hold: 0, exp_n: 10, exp_tr: 0, exp_res: 15};
    tbl[3] = '{a: 7,   b: 9,   bud: 0,  d: 1,  hold: 0, exp_n: 1,  exp_tr: 0, exp_res: 63};
    tbl[5] = '{a: 255, b: 255, bud: 0,  d: 3,  hold: 0, exp_n: 3,  exp_tr: 0, exp_res: 16'hFE01};

    // Reset state
    #12;
    chk("rst_inrdy", in_ready, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_en", core_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_cycles", out_cycles, 0);
    chk("rst_trunc", out_truncated, 0);
    chk("rst_core_data", core_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_inrdy_low", in_ready, 0);
    @(negedge clk);
    chk("rel_inrdy_high", in_ready, 1);

    for (int i = 0; i < 6; i++) do_op(tbl[i]);

    // Randomized operations against the reference rules
    for (int i = 0; i < 25; i++) begin
      v.a    = 8'($urandom);
      v.b    = 8'($urandom);
      v.d    = $urandom_range(1, 30);
      v.bud  = ($urandom_range(0, 1) == 0) ? 17'd0 : 17'($urandom_range(1, 35));
      v.hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      v.exp_n  = v.d;
      v.exp_tr = 1'b0;
`ifdef DSC_EARLY_TERM_EN
      if (v.bud != 0 && int'(v.bud) < v.d) begin
        v.exp_n  = int'(v.bud);
        v.exp_tr = 1'b1;
      end
`endif
      v.exp_res = v.exp_tr ? 16'(v.exp_n) : 16'(v.a) * 16'(v.b);
      do_op(v);
    end

    // Reset in the middle of RUN after 5 counted cycles
    d_cfg     = 20;
    in_data   = 16'h0503;
    in_budget = '0;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (lat < 7) begin @(negedge clk); lat++; end
    chk("mid_run_en", core_en, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", core_en, 0);
    chk("mid_rst_core_rst", core_rst, 1);
    chk("mid_rst_inrdy", in_ready, 0);
    chk("mid_rst_data", core_data, 0);
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_valid", out_valid, 0);
    end
    rst_n = 1'b1;
    #1 chk("mid_rel_inrdy_low", in_ready, 0);
    @(negedge clk);
    chk("mid_rel_inrdy", in_ready, 1);
    chk("mid_rel_valid", out_valid, 0);
    repeat (3) @(negedge clk);
    chk("mid_idle_valid", out_valid, 0);
    v = '{a: 2, b: 3, bud: 0, d: 2, hold: 0, exp_n: 2, exp_tr: 0, exp_res: 6};
    do_op(v);

    // Narrow counter with a core that never finishes: saturates at 15
    in_valid_b = 1'b1;
    lat = 0;
    while (!in_ready_b && lat < 20) begin @(negedge clk); lat++; end
    chk("sat_ready", in_ready_b, 1);
    @(negedge clk);
    in_valid_b = 1'b0;
    lat = 1;
    while (!out_valid_b && lat < 100) begin @(negedge clk); lat++; end
    chk("sat_latency", lat, 18);
    chk("sat_cycles", out_cycles_b, 15);
    chk("sat_trunc", out_truncated_b, 1);
    chk("sat_result", out_result_b, 16'h1234);
    chk("sat_data", core_data_b, 16'h0201);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsc_op_sequencer.md
# dsc_op_sequencer

- Control stage directly upstream of the DSC `core`.
- Accepts one operand set per operation over a valid/ready handshake and holds it stable on the core inputs.
- Clears and enables the core, counts run cycles, and ends the operation on `core_done` or an optional cycle budget.
- Returns the result and its cycle count downstream over a second valid/ready handshake.

## Interface

Parameters:
- `DATA_WIDTH`, 8, width of one operand.
- `NUM_INPUTS`, 2, operands per operation.
- `CNT_WIDTH`, `NUM_INPUTS*DATA_WIDTH+1`, cycle counter width (WXIP1 equivalent).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operand set valid.
- `in_ready`  out  1  sequencer can accept.
- `in_data`  in  NUM_INPUTS*DATA_WIDTH  packed operands, operand i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `in_budget`  in  CNT_WIDTH  cycle budget, sampled with `in_data`; 0 = unlimited.
- `core_rst`  out  1  active-high clear to core and its counter.
- `core_en`  out  1  core enable.
- `core_data`  out  NUM_INPUTS*DATA_WIDTH  registered operands to core.
- `core_result`  in  NUM_INPUTS*DATA_WIDTH  core binary output.
- `core_done`  in  1  core `op_finished`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `out_result`  out  NUM_INPUTS*DATA_WIDTH  captured result.
- `out_cycles`  out  CNT_WIDTH  RUN cycles consumed.
- `out_truncated`  out  1  ended by budget or counter saturation, not `core_done`.

## Operation

FSM states: IDLE, CLEAR, RUN, DRAIN, HOLD.

- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: capture `in_data` into `core_data` and `in_budget` into the budget register, then go to CLEAR.
- **CLEAR**
  - Lasts one cycle with `core_rst`=1, `core_en`=0.
  - Cycle counter cleared to 0; go to RUN.
- **RUN**
  - `core_rst`=0, `core_en`=1; counter increments by 1 each cycle.
  - Exit to DRAIN when either terminate condition holds (evaluated on count including the current cycle):
    - `core_done`=1; or
    - budget≠0 and count==budget (budget only with the macro); or
    - count==all-ones (saturation).
  - Record `out_truncated`=1 iff `core_done`=0 at exit.
  - If `core_done` and budget coincide, `core_done` wins and `out_truncated`=0.
- **DRAIN**
  - One cycle with `core_en`=0 so the core output settles.
  - Capture `core_result` into `out_result` and count into `out_cycles`; go to HOLD.
- **HOLD**
  - `out_valid`=1; outputs stable until `out_ready`.
  - On the handshake: `out_valid`→0, `core_rst`→1, go to IDLE.
- `core_data` stays constant from CLEAR through HOLD.
- `in_ready`=0 outside IDLE.

Reset (`rst_n` low, any state, including mid-RUN):
- State→IDLE, `in_ready`=0, `core_rst`=1, `core_en`=0, `out_valid`=0, `out_result`=0, `out_cycles`=0, `out_truncated`=0, `core_data`=0.
- `in_ready` rises on the first clock edge after deassertion.

## Timing

- All outputs are registered.
- Input accept edge = cycle 0; CLEAR = cycle 1; RUN spans cycles 2..N+1 for N RUN cycles; DRAIN = N+2; `out_valid` high from cycle N+3.
- With `out_ready` held high, `in_ready` reasserts at cycle N+4. Back-to-back throughput is one operation per N+4 cycles.
- `out_cycles`=N exactly.

## Configuration

- `DSC_EARLY_TERM_EN` defined:
  - Budget register and comparator are present.
  - A nonzero `in_budget` truncates RUN at that count.
- Undefined:
  - `in_budget` is ignored and no budget logic is synthesized.
  - RUN ends only on `core_done` or saturation.

## Structure

- `dsc_pkg` holds:
  - the state enum;
  - the `CNT_WIDTH` derivation function;
  - the `MIN_CYC_DSC` constant, shared with bench MAE normalisation.
- Sub-module: the existing `counter` (WIDTH=CNT_WIDTH, STRIDE=1), with `rst` driven by `core_rst` and `en` by the RUN state. Its `overflow` output is not used for termination; saturation is detected at all-ones.

## Test plan

Bench uses a behavioural core model that asserts `core_done` after D RUN cycles with a fixed result.

1. Operands 3,5; D=10; `out_ready`=1 → `out_valid` at cycle 13, `out_result`=15, `out_cycles`=10, `out_truncated`=0; `core_data`=0x0503 throughout.
2. Macro on, budget=4, D=10 → `out_cycles`=4, `out_truncated`=1, result sampled in DRAIN. Budget=10, D=10 → `out_truncated`=0.
3. Macro off, budget=4, D=10 → `out_cycles`=10, `out_truncated`=0.
4. `out_ready` held low 5 cycles in HOLD → outputs stable, `in_ready`=0. A second queued `in_valid` is accepted the cycle after the handshake.
5. `rst_n` pulsed low at RUN count 5 → `core_en`=0 and `core_rst`=1 immediately, `out_valid` stays 0, `in_ready`=1 the first edge after release.
6. `CNT_WIDTH`=4, core never done → `out_cycles`=15, `out_truncated`=1.
